// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the shared data_bus.
// Requests are checked, then driven onto the bus for LATENCY cycles.
module mem_arbiter #(
  parameter int unsigned LATENCY = 1,
  parameter logic [31:0] MEM_END = 32'h0000_ffff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_len,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_len,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        bus_rw,
  output logic [1:0]  bus_len,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_write,
  input  logic [31:0] bus_read,
  input  logic        bus_exception,
  output logic [1:0]  grant
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nx;

  logic          last;
  logic [CW-1:0] cnt;
  logic          err_q;

  logic          any_req;
  logic          pick;
  logic          we_s;
  logic [1:0]    len_s;
  logic [31:0]   addr_s;
  logic [31:0]   wdata_s;
  logic          req_ok;

  always_comb begin
    any_req = m0_req | m1_req;
    // On a tie the master that did not win last time goes first
    if (m0_req && m1_req)
      pick = ~last;
    else
      pick = m1_req;
    we_s    = pick ? m1_we    : m0_we;
    len_s   = pick ? m1_len   : m0_len;
    addr_s  = pick ? m1_addr  : m0_addr;
    wdata_s = pick ? m1_wdata : m0_wdata;
    req_ok  = 1'b0;
    unique case (len_s)
      2'b00:   req_ok = 1'b1;
      2'b01:   req_ok = ~addr_s[0];
      2'b10:   req_ok = (addr_s[1:0] == 2'b00);
      default: req_ok = 1'b0;
    endcase
    if (addr_s > MEM_END)
      req_ok = 1'b0;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (any_req)
          state_nx = req_ok ? ACCESS : RESP;
      ACCESS:
        if (cnt == '0)
          state_nx = RESP;
      RESP:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      cnt       <= '0;
      err_q     <= 1'b0;
      grant     <= 2'b00;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      bus_rw    <= 1'b0;
      bus_len   <= 2'b00;
      bus_addr  <= '0;
      bus_write <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick ? 2'b10 : 2'b01;
            last  <= pick;
            if (req_ok) begin
              bus_rw    <= we_s;
              bus_len   <= len_s;
              bus_addr  <= addr_s;
              bus_write <= wdata_s;
              cnt       <= CW'(LATENCY - 1);
              err_q     <= 1'b0;
            end else begin
              err_q <= 1'b1;
              if (pick)
                m1_rdata <= '0;
              else
                m0_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            err_q <= bus_exception;
            if (grant[1])
              m1_rdata <= bus_read;
            else
              m0_rdata <= bus_read;
          end
        end
        RESP: begin
          bus_rw <= 1'b0;
          grant  <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign m0_ack = (state == RESP) & grant[0];
  assign m1_ack = (state == RESP) & grant[1];
  assign m0_err = m0_ack & err_q;
  assign m1_err = m1_ack & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model,
// directed spec scenarios and randomized two-master traffic.
module tb_mem_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam logic [31:0] MEND = 32'h0000_0fff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction

  function automatic logic ex_fn(input logic [31:0] a);
    return a[11:9] == 3'b111;
  endfunction

  function automatic bit ok_fn(input logic [1:0] l,
                               input logic [31:0] a);
    if (a > MEND) return 1'b0;
    if (l == 2'd3) return 1'b0;
    return (a % (32'd1 << l)) == 0;
  endfunction

  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [1:0]  len [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        bus_rw, bus_exc;
  logic [1:0]  bus_len, gnt;
  logic [31:0] bus_addr, bus_write, bus_read;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;

  assign bus_read = ovr_en ? ovr_val : rd_fn(bus_addr);
  assign bus_exc  = ex_fn(bus_addr);

  mem_arbiter #(.LATENCY(LAT0), .MEM_END(MEND)) u0 (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_len(len[0]),
    .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ack(ack0), .m0_rdata(rdata0), .m0_err(err0),
    .m1_req(req[1]), .m1_we(we[1]), .m1_len(len[1]),
    .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_ack(ack1), .m1_rdata(rdata1), .m1_err(err1),
    .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr),
    .bus_write(bus_write), .bus_read(bus_read),
    .bus_exception(bus_exc), .grant(gnt)
  );

  logic        u1_req = 1'b0;
  logic [31:0] u1_addr = '0;
  logic        u1_ack0, u1_ack1, u1_err0, u1_err1, u1_rw;
  logic [31:0] u1_rd0, u1_rd1, u1_baddr, u1_bwrite;
  logic [1:0]  u1_len, u1_gnt;
  wire  [31:0] u1_bread = rd_fn(u1_baddr);
  wire         u1_bexc = ex_fn(u1_baddr);

  mem_arbiter #(.LATENCY(LAT1), .MEM_END(MEND)) u1 (
    .clk(clk), .rst(rst),
    .m0_req(1'b0), .m0_we(1'b0), .m0_len(2'b00),
    .m0_addr(32'h0), .m0_wdata(32'h0),
    .m0_ack(u1_ack0), .m0_rdata(u1_rd0), .m0_err(u1_err0),
    .m1_req(u1_req), .m1_we(1'b0), .m1_len(2'b10),
    .m1_addr(u1_addr), .m1_wdata(32'h0),
    .m1_ack(u1_ack1), .m1_rdata(u1_rd1), .m1_err(u1_err1),
    .bus_rw(u1_rw), .bus_len(u1_len), .bus_addr(u1_baddr),
    .bus_write(u1_bwrite), .bus_read(u1_bread),
    .bus_exception(u1_bexc), .grant(u1_gnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  int          cyc = 0;
  bit          busy = 0;
  int          ack_e = 0;
  int          next_g = 0;
  bit          last_m = 1;
  bit          m_own, m_ok, m_we;
  logic [1:0]  m_len;
  logic [31:0] m_addr, m_wd;
  logic [31:0] exp_rd [2];
  bit          exp_err;
  int          mode [2];
  bit          waiting [2];
  bit          gq [$];

  task automatic new_req(input int m);
    int r;
    r = $urandom_range(7);
    len[m]   = (r < 7) ? 2'(r % 3) : 2'd3;
    addr[m]  = $urandom & 32'h0000_0fff;
    if ($urandom_range(3) != 0)
      addr[m] = addr[m] & ~((32'd1 << len[m]) - 1);
    if ($urandom_range(9) == 0)
      addr[m] = MEND + 1 + $urandom_range(63);
    we[m]    = 1'($urandom_range(1));
    wdata[m] = $urandom;
    req[m]   = 1'b1;
  endtask

  task automatic step();
    bit         was_rst;
    logic [1:0] ea, eg;
    logic [1:0] acks;
    was_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) begin
      busy = 0;
      last_m = 1;
      next_g = cyc + 1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else begin
      if (busy && cyc > ack_e) busy = 0;
      if (!busy && cyc >= next_g && (req != 2'b00)) begin
        m_own  = (req == 2'b11) ? !last_m : req[1];
        last_m = m_own;
        m_we   = we[m_own];
        m_len  = len[m_own];
        m_addr = addr[m_own];
        m_wd   = wdata[m_own];
        m_ok   = ok_fn(m_len, m_addr);
        busy   = 1;
        ack_e  = cyc + (m_ok ? LAT0 : 0);
        next_g = ack_e + 2;
        gq.push_back(m_own);
      end
      if (busy && cyc == ack_e) begin
        exp_rd[m_own] = !m_ok ? 32'h0 :
                        ovr_en ? ovr_val : rd_fn(m_addr);
        exp_err = m_ok ? ex_fn(m_addr) : 1'b1;
      end
    end
    ea = 2'b00;
    eg = 2'b00;
    if (busy) begin
      eg = m_own ? 2'b10 : 2'b01;
      if (cyc == ack_e) ea = eg;
    end
    check("ack0", 32'(ack0), 32'(ea[0]));
    check("ack1", 32'(ack1), 32'(ea[1]));
    check("err0", 32'(err0), 32'(ea[0] & exp_err));
    check("err1", 32'(err1), 32'(ea[1] & exp_err));
    check("grant", 32'(gnt), 32'(eg));
    check("bus_rw", 32'(bus_rw), 32'(busy && m_ok && m_we));
    check("rdata0", rdata0, exp_rd[0]);
    check("rdata1", rdata1, exp_rd[1]);
    if (busy && m_ok) begin
      check("bus_addr", bus_addr, m_addr);
      check("bus_write", bus_write, m_wd);
      check("bus_len", 32'(bus_len), 32'(m_len));
    end
    acks = {ack1, ack0};
    for (int m = 0; m < 2; m++) begin
      if (acks[m]) begin
        waiting[m] = 0;
        if (mode[m] != 1) req[m] = 1'b0;
      end else if (mode[m] == 2 && req[m] && gnt[m] &&
                   $urandom_range(5) == 0) begin
        req[m] = 1'b0;
        waiting[m] = 1;
      end
      if (mode[m] == 2 && !req[m] && !waiting[m] &&
          $urandom_range(2) == 0)
        new_req(m);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, held;
    bit  rw_seen, any_ack;
    logic [1:0]  bl [3];
    logic [31:0] ba [3];
    for (int m = 0; m < 2; m++) begin
      len[m] = 2'b00;
      addr[m] = '0;
      wdata[m] = '0;
      mode[m] = 0;
      waiting[m] = 0;
    end

    // reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_busaddr", bus_addr, 32'h0);

    // m0 byte read, LATENCY=1
    ovr_en = 1'b1;
    ovr_val = 32'h0000_00a5;
    we[0] = 1'b0; len[0] = 2'b00; addr[0] = 32'h10;
    req[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n++;
      if (ack0) break;
    end
    check("m0_rd_lat", 32'(n), 32'(LAT0 + 1));
    check("m0_rd_data", rdata0, 32'h0000_00a5);
    check("m0_rd_err", 32'(err0), 32'h0);
    step();
    ovr_en = 1'b0;

    // m1 word write
    we[1] = 1'b1; len[1] = 2'b10; addr[1] = 32'h20;
    wdata[1] = 32'hdeadbeef;
    req[1] = 1'b1;
    step();
    check("m1_wr_rw", 32'(bus_rw), 32'h1);
    check("m1_wr_addr", bus_addr, 32'h20);
    check("m1_wr_data", bus_write, 32'hdeadbeef);
    step();
    check("m1_wr_ack", 32'(ack1), 32'h1);
    step();
    check("m1_wr_rw_off", 32'(bus_rw), 32'h0);

    // continuous contention
    we = 2'b00;
    len[0] = 2'b00; addr[0] = 32'h100;
    len[1] = 2'b01; addr[1] = 32'h202;
    mode[0] = 1; mode[1] = 1;
    gq.delete();
    req = 2'b11;
    for (int i = 0; i < 100 && gq.size() < 6; i++) step();
    req = 2'b00;
    mode[0] = 0; mode[1] = 0;
    repeat (6) step();
    check("rr_count", 32'(gq.size()), 32'd6);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      check("rr_order", 32'(gq[i]), 32'(i % 2));

    // rejected requests on m0
    bl[0] = 2'b10; ba[0] = 32'h22;
    bl[1] = 2'b00; ba[1] = MEND + 1;
    bl[2] = 2'b11; ba[2] = 32'h40;
    for (int k = 0; k < 3; k++) begin
      we[0] = 1'b1; len[0] = bl[k]; addr[0] = ba[k];
      wdata[0] = 32'h1234_5678;
      req[0] = 1'b1;
      n = 0;
      rw_seen = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        n++;
        if (bus_rw) rw_seen = 1;
        if (ack0) break;
      end
      check("bad_lat", 32'(n), 32'd1);
      check("bad_err", 32'(err0), 32'h1);
      check("bad_rdata", rdata0, 32'h0);
      check("bad_rw", 32'(rw_seen), 32'h0);
      step();
    end

    // reset in the middle of an access
    we[1] = 1'b1; len[1] = 2'b10; addr[1] = 32'h30;
    wdata[1] = 32'hcafef00d;
    req[1] = 1'b1;
    step();
    check("mid_rw", 32'(bus_rw), 32'h1);
    req[1] = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("mid_grant", 32'(gnt), 32'h0);
    check("mid_rw_off", 32'(bus_rw), 32'h0);
    any_ack = 0;
    repeat (5) begin
      step();
      any_ack |= ack0 | ack1;
    end
    check("mid_no_ack", 32'(any_ack), 32'h0);

    // randomized traffic
    mode[0] = 2; mode[1] = 2;
    repeat (2000) step();
    mode[0] = 0; mode[1] = 0;
    repeat (20) step();
    check("drain_req", 32'(req), 32'h0);

    // LATENCY=3 read with bus exception
    u1_addr = 32'h0000_0e04;
    u1_req = 1'b1;
    n = 0;
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (u1_ack1) break;
      if (u1_gnt == 2'b10 && u1_baddr == u1_addr) held++;
    end
    u1_req = 1'b0;
    check("l3_lat", 32'(n), 32'(LAT1 + 1));
    check("l3_err", 32'(u1_err1), 32'h1);
    check("l3_rdata", u1_rd1, rd_fn(32'h0000_0e04));
    check("l3_held", 32'(held), 32'(LAT1));
    check("l3_ack0", 32'(u1_ack0), 32'h0);
    @(posedge clk);
    #1;
    check("l3_grant_off", 32'(u1_gnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
